// File: rtl/seq_mult_hs_if.sv
// -----------------------------------------------------------------------------
// seq_mult_hs_if
//   Handshake bundle for seq_mult_hs: the operand channel (in_*, A, B), the
//   result channel (out_*, product) and the busy status flag.
//
//   Modports:
//     master : operand producer / result consumer side
//              (drives in_valid, in_signed, A, B, out_ready)
//     slave  : multiplier side
//              (drives in_ready, out_valid, product, busy)
// -----------------------------------------------------------------------------
interface seq_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, in_signed, A, B, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, in_signed, A, B, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// -----------------------------------------------------------------------------
// seq_mult_hs
//   Iterative shift-and-add multiplier with valid/ready handshakes on both
//   sides, per-operation signed/unsigned mode and BITS_PER_CYCLE multiplier
//   bits retired per clock.  Signed operands are reduced to magnitudes on
//   acceptance; the sign is re-applied once when the result is registered.
//
//   Parameters:
//     WIDTH          operand width (>= 2)
//     BITS_PER_CYCLE 1, 2 or 4; must divide WIDTH
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  seq_mult_hs_if.slave
//            in_valid/in_ready/in_signed/A/B : operand channel
//            out_valid/out_ready/product     : result channel
//            busy                            : high in CALC or DONE
//
//   Build option:
//     SEQ_MULT_EARLY_TERM_EN  when defined, CALC ends as soon as the remaining
//                             multiplier bits are all zero (data-dependent
//                             latency, identical results).
//
//   Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module seq_mult_hs #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult_hs_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               neg;
  logic [PW-1:0]      product_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number.
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign a_neg = bus.in_signed & bus.A[WIDTH-1];
  assign b_neg = bus.in_signed & bus.B[WIDTH-1];
  assign a_mag = a_neg ? ('0 - bus.A) : bus.A;
  assign b_mag = b_neg ? ('0 - bus.B) : bus.B;

  // Partial product for this step: sum of mcand shifted by each set bit of
  // the low BITS_PER_CYCLE multiplier bits.
  logic [PW-1:0]      pp;
  logic [PW-1:0]      acc_next;
  logic [PW-1:0]      acc_neg;
  logic [PW-1:0]      mcand_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               last;

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // written variable a default first, so no latch can be inferred.
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  assign acc_next    = acc + pp;
  // Two's complement of zero is zero, so a zero product never turns negative.
  assign acc_neg     = '0 - acc_next;
  assign mcand_next  = mcand << BITS_PER_CYCLE;
  assign mplier_next = mplier >> BITS_PER_CYCLE;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once no multiplier bits remain; later steps would only add zero.
  assign last = (count == CNT_W'(1)) || (mplier_next == '0);
`else
  assign last = (count == CNT_W'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the whole datapath is cleared on reset (there is no memory array
    // here), so an aborted operation can never leak into a later result.
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      neg         <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          // in_ready_q is always high here, so in_valid alone is the handshake.
          if (bus.in_valid) begin
            mcand      <= PW'(a_mag);
            mplier     <= b_mag;
            neg        <= bus.in_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            acc        <= '0;
            count      <= CNT_W'(N);
            state      <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          count  <= count - CNT_W'(1);
          if (last) begin
            product_q   <= neg ? acc_neg : acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          // in_ready returns one cycle after this handshake; no same-cycle
          // restart.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_hs
//   Three seq_mult_hs instances (WIDTH=8, BITS_PER_CYCLE = 1, 2, 4), each
//   driven through its own seq_mult_hs_if. A vector table covers the listed
//   corner products and latencies; hand sequences cover backpressure and
//   reset mid-CALC; a random phase compares against the `*` operator.
//   Expected products are queued when operands are offered and popped when
//   the result handshake happens.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_mult_hs;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0]        in_valid_r;
  logic [NDUT-1:0]        in_signed_r;
  logic [NDUT-1:0][7:0]   a_r;
  logic [NDUT-1:0][7:0]   b_r;
  logic [NDUT-1:0]        out_ready_r;
  logic [NDUT-1:0]        in_ready_w;
  logic [NDUT-1:0]        out_valid_w;
  logic [NDUT-1:0]        busy_w;
  logic [NDUT-1:0][15:0]  product_w;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    seq_mult_hs_if #(.WIDTH(8)) ifc ();

    assign ifc.in_valid  = in_valid_r[g];
    assign ifc.in_signed = in_signed_r[g];
    assign ifc.A         = a_r[g];
    assign ifc.B         = b_r[g];
    assign ifc.out_ready = out_ready_r[g];
    assign in_ready_w[g]  = ifc.in_ready;
    assign out_valid_w[g] = ifc.out_valid;
    assign busy_w[g]      = ifc.busy;
    assign product_w[g]   = ifc.product;

    seq_mult_hs #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] sb [NDUT][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bpc_of(input int sel);
    return 1 << sel;
  endfunction

  // Cycles from acceptance edge to out_valid for this build.
  function automatic int exp_lat_f(input int sel, input logic sgn, input logic [7:0] b);
    logic [7:0] m;
    int         msb;
    m   = (sgn && b[7]) ? (~b + 8'd1) : b;
    msb = -1;
    for (int i = 0; i < 8; i++) if (m[i]) msb = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (msb < 0) return 1;
    return (msb + bpc_of(sel)) / bpc_of(sel);
`else
    return (msb < 0) ? 8 / bpc_of(sel) : 8 / bpc_of(sel);
`endif
  endfunction

  // One complete operation on DUT `sel`. Inputs change on negedge; outputs
  // are sampled on negedge.
  task automatic do_op(input int sel, input logic sgn, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp,
                       input int exp_lat, input int stall, input int gap);
    int cyc;
    repeat (gap) @(negedge clk);
    cyc = 0;
    while (!in_ready_w[sel] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("dut%0d in_ready before accept", sel), 32'(in_ready_w[sel]), 32'd1);

    in_valid_r[sel]  = 1'b1;
    in_signed_r[sel] = sgn;
    a_r[sel]         = a;
    b_r[sel]         = b;
    sb[sel].push_back(exp);
    @(negedge clk);
    in_valid_r[sel] = 1'b0;
    a_r[sel]        = 8'h5A;
    b_r[sel]        = 8'hC3;
    check($sformatf("dut%0d busy after accept", sel), 32'(busy_w[sel]), 32'd1);
    check($sformatf("dut%0d in_ready after accept", sel), 32'(in_ready_w[sel]), 32'd0);

    cyc = 0;
    while (!out_valid_w[sel] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("dut%0d out_valid reached", sel), 32'(out_valid_w[sel]), 32'd1);
    check($sformatf("dut%0d latency A=%0h B=%0h", sel, a, b), 32'(cyc), 32'(exp_lat));

    // Stall: product must hold and a new offer must be ignored.
    for (int s = 0; s < stall; s++) begin
      in_valid_r[sel]  = 1'b1;
      in_signed_r[sel] = ~sgn;
      a_r[sel]         = 8'hAA;
      b_r[sel]         = 8'h55;
      @(negedge clk);
      check($sformatf("dut%0d stall%0d out_valid", sel, s), 32'(out_valid_w[sel]), 32'd1);
      check($sformatf("dut%0d stall%0d in_ready", sel, s), 32'(in_ready_w[sel]), 32'd0);
      check($sformatf("dut%0d stall%0d product", sel, s), 32'(product_w[sel]), 32'(exp));
    end
    in_valid_r[sel] = 1'b0;

    out_ready_r[sel] = 1'b1;
    if (sb[sel].size() == 0)
      check($sformatf("dut%0d scoreboard empty at result", sel), 32'd0, 32'd1);
    else
      check($sformatf("dut%0d product A=%0h B=%0h s=%0d", sel, a, b, sgn),
            32'(product_w[sel]), 32'(sb[sel].pop_front()));
    @(negedge clk);
    out_ready_r[sel] = 1'b0;
    check($sformatf("dut%0d out_valid after handshake", sel), 32'(out_valid_w[sel]), 32'd0);
    check($sformatf("dut%0d in_ready after handshake", sel), 32'(in_ready_w[sel]), 32'd1);
    check($sformatf("dut%0d busy after handshake", sel), 32'(busy_w[sel]), 32'd0);
  endtask

  typedef struct {
    int          sel;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic        sgn;
    logic [7:0]  a, b;
    logic [15:0] exp;
    int          lat;

    vecs[0] = '{0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, 8};
    vecs[1] = '{1, 1'b1, 8'h80, 8'h80, 16'h4000, 4, 4};
    vecs[2] = '{1, 1'b1, 8'h80, 8'h01, 16'hFF80, 4, 1};
    vecs[3] = '{2, 1'b0, 8'h37, 8'h00, 16'h0000, 2, 1};
    vecs[4] = '{2, 1'b1, 8'h85, 8'h00, 16'h0000, 2, 1};
    vecs[5] = '{0, 1'b1, 8'hFF, 8'h01, 16'hFFFF, 8, 1};
    vecs[6] = '{2, 1'b1, 8'h7F, 8'h81, 16'hC0FF, 2, 2};
    vecs[7] = '{1, 1'b0, 8'h0C, 8'h0A, 16'h0078, 4, 2};

    rst         = 1'b1;
    in_valid_r  = '0;
    in_signed_r = '0;
    a_r         = '0;
    b_r         = '0;
    out_ready_r = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < NDUT; s++) begin
      check($sformatf("dut%0d reset in_ready", s),  32'(in_ready_w[s]),  32'd1);
      check($sformatf("dut%0d reset out_valid", s), 32'(out_valid_w[s]), 32'd0);
      check($sformatf("dut%0d reset busy", s),      32'(busy_w[s]),      32'd0);
      check($sformatf("dut%0d reset product", s),   32'(product_w[s]),   32'd0);
    end

    // Table-driven corner vectors.
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
      lat = vecs[i].lat_early;
`else
      lat = vecs[i].lat_fixed;
`endif
      do_op(vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].prod, lat, 0, 0);
    end

    // Backpressure: 12 * 10 held for 5 stalled cycles, new offers ignored.
`ifdef SEQ_MULT_EARLY_TERM_EN
    do_op(0, 1'b0, 8'd12, 8'd10, 16'd120, 4, 5, 0);
`else
    do_op(0, 1'b0, 8'd12, 8'd10, 16'd120, 8, 5, 0);
`endif

    // Reset in the middle of CALC on the one-bit-per-cycle instance.
    in_valid_r[0]  = 1'b1;
    in_signed_r[0] = 1'b0;
    a_r[0]         = 8'hFF;
    b_r[0]         = 8'hFF;
    @(negedge clk);
    in_valid_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst midcalc out_valid", 32'(out_valid_w[0]), 32'd0);
    check("rst midcalc busy",      32'(busy_w[0]),      32'd0);
    check("rst midcalc product",   32'(product_w[0]),   32'd0);
    check("rst midcalc in_ready",  32'(in_ready_w[0]),  32'd1);
    check("rst clears dut2 product", 32'(product_w[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef SEQ_MULT_EARLY_TERM_EN
    do_op(0, 1'b0, 8'd3, 8'd5, 16'd15, 3, 0, 0);
`else
    do_op(0, 1'b0, 8'd3, 8'd5, 16'd15, 8, 0, 0);
`endif

    // Random regression against the reference `*` product.
    for (int s = 0; s < NDUT; s++) begin
      for (int n = 0; n < 250; n++) begin
        sgn = 1'($urandom_range(0, 1));
        a   = 8'($urandom);
        b   = 8'($urandom);
        if ($urandom_range(0, 7) == 0) a = 8'h80;
        if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
        if (sgn) exp = 16'($signed(a) * $signed(b));
        else     exp = 16'(a) * 16'(b);
        do_op(s, sgn, a, b, exp, exp_lat_f(s, sgn, b),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
    end

    for (int s = 0; s < NDUT; s++)
      check($sformatf("dut%0d scoreboard drained", s), 32'(sb[s].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
